// File: rtl/insn_stream_feeder.sv
// insn_stream_feeder: buffers raw day-10 instructions (noop / addx V) in a
// small FIFO and expands them into one {op, arg} word per consumer cycle.
// noop -> {0,0}; addx V -> {0,0} then {1,V}. A bubble (empty FIFO) reads as
// {0,0} and is flagged as a sticky underrun when consumed.
// Optional macro FEEDER_PC_CHECK_EN: when defined, the consumer's pc is
// compared against the consumed-word count on every en cycle and a mismatch
// sets the sticky pc_err flag; when undefined, pc is ignored and pc_err is 0.
module insn_stream_feeder #(
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic               CLK,
  input  logic               RST,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               in_addx,
  input  logic signed [15:0] in_arg,
  input  logic               en,
  input  logic [11:0]        pc,
  output logic [16:0]        data_out,
  output logic [11:0]        cycle_cnt,
  output logic [AW:0]        fifo_level,
  output logic               underrun,
  output logic               pc_err
);

  typedef enum logic {FETCH = 1'b0, ADD = 1'b1} state_t;

  // FIFO storage is pure data and carries no reset.
  logic [16:0]        mem_q [DEPTH];
  logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]        level_q, level_d;
  state_t             state_q, state_d;
  logic signed [15:0] arg_q, arg_d;
  logic [11:0]        cnt_q, cnt_d;
  logic               underrun_q, underrun_d;

  logic               full, empty, push, pop;
  logic [16:0]        head;

  // Next-state: FIFO bookkeeping, instruction expansion, counters.
  always_comb begin
    full       = (level_q == (AW+1)'(DEPTH));
    empty      = (level_q == '0);
    head       = mem_q[rd_ptr_q];
    push       = in_valid && !full;
    pop        = 1'b0;
    state_d    = state_q;
    arg_d      = arg_q;
    underrun_d = underrun_q;

    case (state_q)
      FETCH: begin
        if (en) begin
          if (empty) begin
            underrun_d = 1'b1;
          end else begin
            pop = 1'b1;
            if (head[16]) begin
              state_d = ADD;
              arg_d   = head[15:0];
            end
          end
        end
      end
      ADD: begin
        // Second half of an addx; the instruction was already popped.
        if (en) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    case ({push, pop})
      2'b10:   level_d = level_q + (AW+1)'(1);
      2'b01:   level_d = level_q - (AW+1)'(1);
      default: level_d = level_q;
    endcase

    cnt_d = (en && cnt_q != 12'hFFF) ? cnt_q + 12'd1 : cnt_q;
  end

  // FIFO write port.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q] <= {in_addx, in_arg};
  end

  // Control and FSM state; reset discards queued and half-emitted work.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      state_q    <= FETCH;
      arg_q      <= '0;
      cnt_q      <= '0;
      underrun_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      state_q    <= state_d;
      arg_q      <= arg_d;
      cnt_q      <= cnt_d;
      underrun_q <= underrun_d;
    end
  end

`ifdef FEEDER_PC_CHECK_EN
  logic pc_err_q, pc_err_d;

  // Sticky pc cross-check against the count of words consumed so far.
  always_comb begin
    pc_err_d = pc_err_q | (en && (pc != cnt_q));
  end

  // pc_err flag register.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) pc_err_q <= 1'b0;
    else     pc_err_q <= pc_err_d;
  end

  assign pc_err = pc_err_q;
`else
  logic unused_pc;
  assign unused_pc = ^pc;
  assign pc_err    = 1'b0;
`endif

  assign in_ready   = !full;
  assign data_out   = (state_q == ADD) ? {1'b1, arg_q} : 17'h00000;
  assign cycle_cnt  = cnt_q;
  assign fifo_level = level_q;
  assign underrun   = underrun_q;

endmodule

// File: doc/insn_stream_feeder.md
Name: insn_stream_feeder

Overview:
- Instruction-side partner of the day-10 signal-strength CPU core.
- Accepts raw puzzle instructions (noop / addx V) over a valid/ready interface and buffers them in a small FIFO.
- Expands each instruction into per-cycle words {op, arg}, one word per consumer cycle. noop gives 1 word; addx gives 2 words, with the add on the second.
- Drives the core's 17-bit instruction input and cross-checks the core's pc output against its own cycle count.

Parameters:
- DEPTH, 16, raw-instruction FIFO entries; power of two, at least 2.
- AW, 4, FIFO address width; log2(DEPTH).

Ports:
- CLK  in  1  system clock
- RST  in  1  asynchronous reset, active-high
- in_valid  in  1  producer presents a raw instruction
- in_ready  out  1  feeder can accept; equals !full
- in_addx  in  1  1 = addx, 0 = noop
- in_arg  in  16  addx operand, two's complement; ignored for noop
- en  in  1  consumer consumes the current word this cycle
- pc  in  12  consumer's program counter
- data_out  out  17  word to consumer: bit16 = op, [15:0] = arg
- cycle_cnt  out  12  number of words consumed since reset
- fifo_level  out  AW+1  occupied FIFO entries
- underrun  out  1  sticky: a word was consumed while no instruction was available
- pc_err  out  1  sticky: pc/cycle mismatch (see Optional Feature)

Behaviour:
- Interface: one clock (CLK). Reset RST is asynchronous, active-high.
- Reset values:
  - FIFO empty, fifo_level 0.
  - state FETCH, arg_q 0.
  - cycle_cnt 0, underrun 0, pc_err 0.
  - in_ready 1, data_out 17'h00000.
- Reset mid-operation discards buffered instructions and any half-emitted addx.
- Push: the FIFO writes when in_valid && in_ready at the posedge.
  - The entry is visible at the FIFO head from the next cycle.
  - Push is never accepted while full, even if a pop occurs in the same cycle.
- Simultaneous push and pop when neither full nor empty: fifo_level is unchanged.
- Read and write pointers wrap modulo DEPTH. fifo_level distinguishes full from empty.
- State machine, FETCH state (data_out is combinational from state and FIFO head):
  - FIFO empty: data_out = {0,0}. If en, set underrun and advance no state.
  - Head is noop: data_out = {0,0}. If en, pop and stay in FETCH.
  - Head is addx: data_out = {0,0}. If en, pop, arg_q <= in_arg of head, go to ADD.
- State machine, ADD state:
  - data_out = {1,arg_q}.
  - If en, go to FETCH. No pop occurs in ADD.
- en low: state, FIFO read side and cycle_cnt hold; data_out stays stable.
- cycle_cnt increments by 1 on every en cycle and saturates at 12'hFFF.
- Arithmetic: arg passes through unmodified. Sign handling belongs to the consumer.
- The block emits no x-update while empty; a bubble is architecturally a noop.

Optional Feature:
- Macro: FEEDER_PC_CHECK_EN.
- Defined: on every en cycle, if pc != cycle_cnt, pc_err is set at that posedge. pc_err is sticky until RST.
- Undefined: the pc input is ignored, pc_err is tied 0, and no comparator is synthesized.

Test Plan:
- Reset, then push noop, addx 3, addx -5 with en held high from the cycle after the third push
  -> data_out sequence 00000, 00000, 10003, 00000, 1FFFB, then 00000 with underrun=1.
  -> cycle_cnt reaches 5 at the first bubble.
- Push DEPTH=16 noops with en low
  -> in_ready drops after the 16th push, fifo_level=16.
  -> a 17th in_valid is not accepted.
- Full FIFO, then pulse en once while in_valid is high
  -> the pop frees a slot; the push is refused that cycle and accepted the next; fifo_level ends at 16.
- addx 7 at head, en high one cycle, then low for 5 cycles
  -> data_out holds 10007 for 5 cycles.
  -> next en returns to FETCH; cycle_cnt=2.
- FEEDER_PC_CHECK_EN defined: drive pc = cycle_cnt+1 on the 3rd en cycle
  -> pc_err=1 after that edge and stays set. Undefined: pc_err stays 0.
- Assert RST asynchronously while in ADD with 4 entries queued
  -> immediately fifo_level=0, data_out=00000, cycle_cnt=0, underrun=0, in_ready=1.
